// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU operations, FSM states and datapath mux selects.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_R_WB     = 4'd3,
    S_EX_I     = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_J        = 4'd11,
    S_JAL      = 4'd12,
    S_EXC      = 4'd13
  } state_t;

  localparam logic       SRC_A_PC   = 1'b0;
  localparam logic       SRC_A_REG  = 1'b1;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic CAUSE_OVF = 1'b0;
  localparam logic CAUSE_ILL = 1'b1;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
      FN_OR, FN_XOR, FN_NOR, FN_SLT: funct_legal = 1'b1;
      default:                       funct_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// Combinational ALU-operation decoder: picks the ALU op for the current
// state and flags whether the fetched instruction is one we implement.
module alu_op_dec
  import mips_defs::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       ext_zero,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = funct_legal(funct);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_op   = ALU_AND;
    ext_zero = 1'b0;
    case (state)
      S_IF, S_ID, S_MEM_ADDR: alu_op = ALU_ADD;
      S_BRANCH:               alu_op = ALU_SUB;
      S_EX_R: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          default:         alu_op = ALU_AND;
        endcase
      end
      S_EX_I: begin
        case (opcode)
          OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
          OP_SLTI:           alu_op = ALU_SLT;
          OP_ORI:            alu_op = ALU_OR;
          OP_XORI:           alu_op = ALU_XOR;
          default:           alu_op = ALU_AND;
        endcase
        ext_zero = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/write-back with
// mem_ready stalls and overflow/illegal-opcode traps to the exception vector.
module mips_multicycle_ctrl
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic [2:0] ALU_operation,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       exc,
  output logic       exc_cause,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic       cause_d;
  logic [2:0] dec_op;
  logic       dec_ext_zero;
  logic       dec_legal;

  alu_op_dec u_alu_op_dec (
    .state    (state_q),
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_op),
    .ext_zero (dec_ext_zero),
    .legal    (dec_legal)
  );

  assign state = state_q;

  // exc_cause only changes on the edge that enters EXC, so it stays readable afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      exc_cause <= CAUSE_OVF;
    end else begin
      state_q <= state_d;
      if (state_d == S_EXC) exc_cause <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = CAUSE_OVF;
    case (state_q)
      S_IF: if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (!dec_legal) begin
          state_d = S_EXC;
          cause_d = CAUSE_ILL;
        end else begin
          case (opcode)
            OP_RTYPE:      state_d = S_EX_R;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:          state_d = S_J;
            OP_JAL:        state_d = S_JAL;
            default:       state_d = S_EX_I;
          endcase
        end
      end
      S_EX_R:
        state_d = (overflow && (funct == FN_ADD || funct == FN_SUB)) ? S_EXC : S_R_WB;
      S_EX_I:
        state_d = (overflow && opcode == OP_ADDI) ? S_EXC : S_I_WB;
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_IF;
      end
      S_MEM_RD: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: if (mem_ready) state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  always_comb begin
    ALU_operation = dec_op;
    ext_zero      = dec_ext_zero;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    pc_source     = PC_ALU;
    pc_en         = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = WB_ALUOUT;
    reg_write     = 1'b0;
    exc           = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        pc_source = PC_ALU;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_ID: alu_src_b = SRC_B_BR;
      S_EX_R: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RD;
        mem_to_reg = WB_ALUOUT;
      end
      S_EX_I, S_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        reg_dst   = DST_RT;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_REG;
        pc_source = PC_ALUOUT;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_J: begin
        pc_source = PC_JUMP;
        pc_en     = 1'b1;
      end
      S_JAL: begin
        pc_source  = PC_JUMP;
        pc_en      = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = WB_PC;
      end
      S_EXC: begin
        pc_source = PC_EXC;
        pc_en     = 1'b1;
        exc       = 1'b1;
      end
      default: ;
    endcase
    // Reset is asynchronous, so outputs are forced quiet without waiting for a clock
    if (rst) begin
      ALU_operation = ALU_ADD;
      ext_zero      = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = '0;
      pc_source     = '0;
      pc_en         = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = '0;
      mem_to_reg    = '0;
      reg_write     = 1'b0;
      exc           = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a per-cycle table of inputs and
// hand-derived expected outputs, plus a reset-during-store sequence.
module tb_mips_multicycle_ctrl;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow, mem_ready;
  logic [2:0] ALU_operation;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] pc_source;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       reg_write, exc, exc_cause;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .ALU_operation(ALU_operation),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_source(pc_source), .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .exc(exc),
    .exc_cause(exc_cause), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic       ez;
    logic [1:0] ps;
    logic       pe, iod, mrd, mwr, irw;
    logic [1:0] rd, m2r;
    logic       rw, ex, cause;
  } out_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z, ov, mr;
    out_t       e;
  } vec_t;

  vec_t tbl[$];
  logic cc;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic out_t mk(input logic [3:0] st, input logic [2:0] alu, input logic sa,
                              input logic [1:0] sb, input logic ez, input logic [1:0] ps,
                              input logic pe, iod, mrd, mwr, irw, input logic [1:0] rd, m2r,
                              input logic rw, ex);
    out_t o;
    o.st = st; o.alu = alu; o.sa = sa; o.sb = sb; o.ez = ez; o.ps = ps;
    o.pe = pe; o.iod = iod; o.mrd = mrd; o.mwr = mwr; o.irw = irw;
    o.rd = rd; o.m2r = m2r; o.rw = rw; o.ex = ex; o.cause = cc;
    return o;
  endfunction

  function automatic out_t f_rst();            return mk(4'd0, 3'b010, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_if(input logic m); return mk(4'd0, 3'b010, 0, 2'b01, 0, 2'b00, m, 0, 1, 0, m, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_id();             return mk(4'd1, 3'b010, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_exr(input logic [2:0] a); return mk(4'd2, a, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_rwb();            return mk(4'd3, 3'b000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0); endfunction
  function automatic out_t f_exi(input logic [2:0] a, input logic z); return mk(4'd4, a, 1, 2'b10, z, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_iwb();            return mk(4'd5, 3'b000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0); endfunction
  function automatic out_t f_madr();           return mk(4'd6, 3'b010, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_mrd();            return mk(4'd7, 3'b000, 0, 2'b00, 0, 2'b00, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_mwb();            return mk(4'd8, 3'b000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0); endfunction
  function automatic out_t f_mwr();            return mk(4'd9, 3'b000, 0, 2'b00, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_br(input logic p); return mk(4'd10, 3'b110, 1, 2'b00, 0, 2'b01, p, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_j();              return mk(4'd11, 3'b000, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); endfunction
  function automatic out_t f_jal();            return mk(4'd12, 3'b000, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0); endfunction
  function automatic out_t f_exc();            return mk(4'd13, 3'b000, 0, 2'b00, 0, 2'b11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1); endfunction

  task automatic push(input logic [5:0] op, fn, input logic z, ov, mr, input out_t e);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.ov = ov; v.mr = mr; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input out_t e);
    out_t act;
    act = {state, ALU_operation, alu_src_a, alu_src_b, ext_zero, pc_source, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, exc, exc_cause};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (st,alu,sa,sb,ez,ps,pe,iod,mrd,mwr,irw,rd,m2r,rw,exc,cause)",
               name, act, e);
    end
  endtask

  // Inputs driven 1 time unit after the edge, outputs checked 1 unit later.
  task automatic step(input vec_t v, input string name);
    opcode = v.op; funct = v.fn; zero = v.z; overflow = v.ov; mem_ready = v.mr;
    #1 check(name, v.e);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [5:0] op, fn, input logic z, ov, mr, input out_t e, input string name);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.ov = ov; v.mr = mr; v.e = e;
    step(v, name);
  endtask

  initial begin
    cc = 1'b0;
    // add, no stalls: 4 cycles
    push(6'h00, 6'h20, 0, 0, 1, f_if(1));
    push(6'h00, 6'h20, 0, 0, 1, f_id());
    push(6'h00, 6'h20, 0, 0, 1, f_exr(3'b010));
    push(6'h00, 6'h20, 0, 0, 1, f_rwb());
    // lw with two wait cycles in MEM_RD
    push(6'h23, 6'h00, 0, 0, 1, f_if(1));
    push(6'h23, 6'h00, 0, 0, 1, f_id());
    push(6'h23, 6'h00, 0, 0, 1, f_madr());
    push(6'h23, 6'h00, 0, 0, 0, f_mrd());
    push(6'h23, 6'h00, 0, 0, 0, f_mrd());
    push(6'h23, 6'h00, 0, 0, 1, f_mrd());
    push(6'h23, 6'h00, 0, 0, 1, f_mwb());
    // sw with one fetch wait cycle
    push(6'h2B, 6'h00, 0, 0, 0, f_if(0));
    push(6'h2B, 6'h00, 0, 0, 1, f_if(1));
    push(6'h2B, 6'h00, 0, 0, 1, f_id());
    push(6'h2B, 6'h00, 0, 0, 1, f_madr());
    push(6'h2B, 6'h00, 0, 0, 1, f_mwr());
    // beq/bne, both zero polarities
    push(6'h04, 6'h00, 1, 0, 1, f_if(1)); push(6'h04, 6'h00, 1, 0, 1, f_id()); push(6'h04, 6'h00, 1, 0, 1, f_br(1));
    push(6'h04, 6'h00, 0, 0, 1, f_if(1)); push(6'h04, 6'h00, 0, 0, 1, f_id()); push(6'h04, 6'h00, 0, 0, 1, f_br(0));
    push(6'h05, 6'h00, 0, 0, 1, f_if(1)); push(6'h05, 6'h00, 0, 0, 1, f_id()); push(6'h05, 6'h00, 0, 0, 1, f_br(1));
    push(6'h05, 6'h00, 1, 0, 1, f_if(1)); push(6'h05, 6'h00, 1, 0, 1, f_id()); push(6'h05, 6'h00, 1, 0, 1, f_br(0));
    // immediate ALU ops
    push(6'h0C, 6'h00, 0, 0, 1, f_if(1)); push(6'h0C, 6'h00, 0, 0, 1, f_id());
    push(6'h0C, 6'h00, 0, 0, 1, f_exi(3'b000, 1)); push(6'h0C, 6'h00, 0, 0, 1, f_iwb());
    push(6'h0A, 6'h00, 0, 0, 1, f_if(1)); push(6'h0A, 6'h00, 0, 0, 1, f_id());
    push(6'h0A, 6'h00, 0, 0, 1, f_exi(3'b111, 0)); push(6'h0A, 6'h00, 0, 0, 1, f_iwb());
    push(6'h0E, 6'h00, 0, 0, 1, f_if(1)); push(6'h0E, 6'h00, 0, 0, 1, f_id());
    push(6'h0E, 6'h00, 0, 0, 1, f_exi(3'b011, 1)); push(6'h0E, 6'h00, 0, 0, 1, f_iwb());
    push(6'h0D, 6'h00, 0, 0, 1, f_if(1)); push(6'h0D, 6'h00, 0, 0, 1, f_id());
    push(6'h0D, 6'h00, 0, 0, 1, f_exi(3'b001, 1)); push(6'h0D, 6'h00, 0, 0, 1, f_iwb());
    // addiu with overflow does not trap
    push(6'h09, 6'h00, 0, 1, 1, f_if(1)); push(6'h09, 6'h00, 0, 1, 1, f_id());
    push(6'h09, 6'h00, 0, 1, 1, f_exi(3'b010, 0)); push(6'h09, 6'h00, 0, 1, 1, f_iwb());
    // R-type op mapping
    push(6'h00, 6'h25, 0, 0, 1, f_if(1)); push(6'h00, 6'h25, 0, 0, 1, f_id());
    push(6'h00, 6'h25, 0, 0, 1, f_exr(3'b001)); push(6'h00, 6'h25, 0, 0, 1, f_rwb());
    push(6'h00, 6'h27, 0, 0, 1, f_if(1)); push(6'h00, 6'h27, 0, 0, 1, f_id());
    push(6'h00, 6'h27, 0, 0, 1, f_exr(3'b100)); push(6'h00, 6'h27, 0, 0, 1, f_rwb());
    push(6'h00, 6'h2A, 0, 0, 1, f_if(1)); push(6'h00, 6'h2A, 0, 0, 1, f_id());
    push(6'h00, 6'h2A, 0, 0, 1, f_exr(3'b111)); push(6'h00, 6'h2A, 0, 0, 1, f_rwb());
    push(6'h00, 6'h26, 0, 0, 1, f_if(1)); push(6'h00, 6'h26, 0, 0, 1, f_id());
    push(6'h00, 6'h26, 0, 0, 1, f_exr(3'b011)); push(6'h00, 6'h26, 0, 0, 1, f_rwb());
    // addi overflow trap
    push(6'h08, 6'h00, 0, 1, 1, f_if(1)); push(6'h08, 6'h00, 0, 1, 1, f_id());
    push(6'h08, 6'h00, 0, 1, 1, f_exi(3'b010, 0));
    cc = 1'b0; push(6'h08, 6'h00, 0, 1, 1, f_exc());
    // illegal opcode 3F
    push(6'h3F, 6'h00, 0, 0, 1, f_if(1)); push(6'h3F, 6'h00, 0, 0, 1, f_id());
    cc = 1'b1; push(6'h3F, 6'h00, 0, 0, 1, f_exc());
    // sub overflow trap, cause returns to 0
    push(6'h00, 6'h22, 0, 1, 1, f_if(1)); push(6'h00, 6'h22, 0, 1, 1, f_id());
    push(6'h00, 6'h22, 0, 1, 1, f_exr(3'b110));
    cc = 1'b0; push(6'h00, 6'h22, 0, 1, 1, f_exc());
    // subu overflow ignored
    push(6'h00, 6'h23, 0, 1, 1, f_if(1)); push(6'h00, 6'h23, 0, 1, 1, f_id());
    push(6'h00, 6'h23, 0, 1, 1, f_exr(3'b110)); push(6'h00, 6'h23, 0, 1, 1, f_rwb());
    // jal, j
    push(6'h03, 6'h00, 0, 0, 1, f_if(1)); push(6'h03, 6'h00, 0, 0, 1, f_id()); push(6'h03, 6'h00, 0, 0, 1, f_jal());
    push(6'h02, 6'h00, 0, 0, 1, f_if(1)); push(6'h02, 6'h00, 0, 0, 1, f_id()); push(6'h02, 6'h00, 0, 0, 1, f_j());
    // R-type with unimplemented funct
    push(6'h00, 6'h00, 0, 0, 1, f_if(1)); push(6'h00, 6'h00, 0, 0, 1, f_id());
    cc = 1'b1; push(6'h00, 6'h00, 0, 0, 1, f_exc());
    push(6'h00, 6'h20, 0, 0, 0, f_if(0));

    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b1;
    cc = 1'b0;
    #2 check("reset_state", f_rst());
    #10 rst = 1'b0;

    cc = 1'b0;
    for (int unsigned i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // reset asserted while a store waits for mem_ready
    cc = 1'b1;
    go(6'h2B, 6'h00, 0, 0, 1, f_if(1), "rst_seq_if");
    go(6'h2B, 6'h00, 0, 0, 1, f_id(), "rst_seq_id");
    go(6'h2B, 6'h00, 0, 0, 1, f_madr(), "rst_seq_madr");
    mem_ready = 1'b0;
    #1 check("rst_seq_mwr_wait", f_mwr());
    #2 rst = 1'b1;
    cc = 1'b0;
    #1 check("rst_seq_async_drop", f_rst());
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_seq_resume_if", f_if(0));
    @(posedge clk);
    #1;
    go(6'h00, 6'h21, 0, 0, 1, f_if(1), "rst_seq_fetch");
    go(6'h00, 6'h21, 0, 0, 1, f_id(), "rst_seq_decode");
    go(6'h00, 6'h21, 0, 0, 1, f_exr(3'b010), "rst_seq_addu");
    go(6'h00, 6'h21, 0, 0, 1, f_rwb(), "rst_seq_wb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
